// File: rtl/uart_pkg.sv
// Shared state encoding and baud-rate helper for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Clock cycles per bit; the integer quotient is intentional.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define which
  // entries are valid, and a reset-free array can map onto RAM.
  always_ff @(posedge clk_100MHz) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter: start + DATA_BITS (LSB first) + optional parity + STOP_BITS.
// Define UART_PARITY_EN to compile in the parity bit (odd/even chosen by parity_odd).
module uart_tx_engine #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          parity_odd,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  import uart_pkg::*;

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_state_t          state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 baud_end;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .push       (push),
    .push_data  (wr_data),
    .pop        (pop),
    .pop_data   (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign wr_ready = ~fifo_full;
  assign push     = wr_valid & wr_ready;
  assign overflow = wr_valid & fifo_full;
  assign busy     = (state != IDLE) | ~fifo_empty;
  assign baud_end = (baud_cnt == DIV_LAST);

  // A new frame is loaded from IDLE, or on the final stop cycle so frames run back to back.
  assign pop = ~fifo_empty &
               ((state == IDLE) ||
                ((state == STOP) && baud_end && (bit_idx == STOP_LAST)));

`ifdef UART_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset)   parity_bit <= 1'b0;
    else if (pop) parity_bit <= ^head ^ parity_odd;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // blocking assignments would let later statements read already-updated state.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else if (pop) begin
      state     <= START;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= head;
      tx        <= 1'b0;
    end else if (state != IDLE) begin
      baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      if (baud_end) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end
          DATA: begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef UART_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            state   <= STOP;
            bit_idx <= '0;
            tx      <= 1'b1;
          end
`endif
          STOP: begin
            if (bit_idx == STOP_LAST) state <= IDLE;
            else                      bit_idx <= bit_idx + 1'b1;
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: 8-bit/depth-4 instance plus a 7-bit, 2-stop instance.
module tb_uart_tx_engine;

  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME  = (1 + 8 + PB + 1) * DIV;
  localparam int FRAME2 = (1 + 7 + PB + 2) * DIV;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] wr_data    = '0;
  logic       wr_valid   = 1'b0;
  logic       parity_odd = 1'b0;
  logic       wr_ready, tx, busy, overflow;
  logic [2:0] fifo_count;

  logic [6:0] wr_data2  = '0;
  logic       wr_valid2 = 1'b0;
  logic       wr_ready2, tx2, busy2, overflow2;
  logic [4:0] fifo_count2;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_tx_engine #(
    .CLK_HZ(100), .BAUD(10), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .parity_odd (parity_odd),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  uart_tx_engine #(
    .CLK_HZ(100), .BAUD(10), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u_dut2 (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .wr_data    (wr_data2),
    .wr_valid   (wr_valid2),
    .wr_ready   (wr_ready2),
    .parity_odd (parity_odd),
    .tx         (tx2),
    .busy       (busy2),
    .fifo_count (fifo_count2),
    .overflow   (overflow2)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  logic tx_log    [0:255];
  logic busy_log  [0:255];
  logic [2:0] count_log [0:255];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100MHz);
  endtask

  function automatic logic line(input int sel);
    return (sel != 0) ? tx2 : tx;
  endfunction

  // Sample one cycle per entry, starting at the next falling edge.
  task automatic run_log(input int sel, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      tx_log[k]    = line(sel);
      busy_log[k]  = (sel != 0) ? busy2 : busy;
      count_log[k] = fifo_count;
    end
  endtask

  task automatic check_seg(input string tag, input int start, input int len, input logic exp);
    logic seen = exp;
    for (int i = start; i < start + len; i++)
      if (tx_log[i] !== exp) seen = tx_log[i];
    check(tag, 32'(seen), 32'(exp));
  endtask

  // Mid-bit sampling receiver; ok stays 0 if no start bit shows within bound cycles.
  task automatic rx_frame(input int sel, input int nbits, input int bound,
                          output logic [8:0] d, output logic p, output logic ok);
    int w = 0;
    d  = '0;
    p  = 1'b0;
    ok = 1'b0;
    while (line(sel) !== 1'b0 && w < bound) begin
      tick();
      w++;
    end
    if (w >= bound) return;
    repeat (DIV / 2) tick();
    if (line(sel) !== 1'b0) return;
    for (int b = 0; b < nbits; b++) begin
      repeat (DIV) tick();
      d[b] = line(sel);
    end
    if (PB == 1) begin
      repeat (DIV) tick();
      p = line(sel);
    end
    repeat (DIV) tick();
    ok = (line(sel) === 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d8;
    logic [6:0] d7;
    logic [8:0] rd;
    logic       rp, rok;

    // Reset values while reset is held low.
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("rst_tx",       32'(tx),         32'd1);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_wr_ready", 32'(wr_ready),   32'd1);
    check("rst_count",    32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    reset = 1'b1;
    tick();

    // Single 8'hA5 frame.
    d8 = 8'hA5;
    wr_data = d8; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("t1_count_accept", 32'(fifo_count), 32'd1);
    check("t1_tx_accept",    32'(tx),         32'd1);
    run_log(0, FRAME + 1);
    check_seg("t1_start", 0, DIV, 1'b0);
    for (int b = 0; b < 8; b++)
      check_seg($sformatf("t1_bit%0d", b), DIV * (1 + b), DIV, d8[b]);
    if (PB == 1) check_seg("t1_parity", DIV * 9, DIV, 1'b0);
    check_seg("t1_stop", DIV * (9 + PB), DIV, 1'b1);
    check("t1_busy_last", 32'(busy_log[FRAME - 1]), 32'd1);
    check("t1_busy_done", 32'(busy_log[FRAME]),     32'd0);

    // 8'h00 then 8'hFF on consecutive cycles: back-to-back frames.
    wr_data = 8'h00; wr_valid = 1'b1;
    tick();
    check("t2_count_first", 32'(fifo_count), 32'd1);
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    check("t2_count_pushpop", 32'(fifo_count), 32'd1);
    check("t2_first_start",   32'(tx),         32'd0);
    run_log(0, 2 * FRAME);
    check_seg("t2_frame0_low", 0, DIV * (9 + PB) - 1, 1'b0);
    check("t2_last_stop",   32'(tx_log[FRAME - 2]),    32'd1);
    check("t2_next_start",  32'(tx_log[FRAME - 1]),    32'd0);
    check("t2_count_held",  32'(count_log[FRAME - 2]), 32'd1);
    check("t2_count_empty", 32'(count_log[FRAME - 1]), 32'd0);
    check_seg("t2_frame1_data", FRAME - 1 + DIV, 8 * DIV, 1'b1);
    if (PB == 1) check_seg("t2_frame1_parity", FRAME - 1 + 9 * DIV, DIV, 1'b0);
    check_seg("t2_frame1_stop", FRAME - 1 + (9 + PB) * DIV, DIV, 1'b1);
    check("t2_busy_last", 32'(busy_log[2 * FRAME - 2]), 32'd1);
    check("t2_busy_done", 32'(busy_log[2 * FRAME - 1]), 32'd0);

    // Six writes into a depth-4 FIFO while a frame is in flight.
    wr_data = 8'hFF; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    repeat (15) tick();
    for (int i = 0; i < 6; i++) begin
      wr_data  = 8'(8'h11 * (i + 1));
      wr_valid = 1'b1;
      #1;
      check($sformatf("t3_ready%0d", i),    32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("t3_overflow%0d", i), 32'(overflow), (i < 4) ? 32'd0 : 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    check("t3_count_full", 32'(fifo_count), 32'd4);
    for (int j = 0; j < 4; j++) begin
      rx_frame(0, 8, 3 * FRAME, rd, rp, rok);
      check($sformatf("t3_rx_ok%0d", j),   32'(rok),     32'd1);
      check($sformatf("t3_rx_data%0d", j), 32'(rd[7:0]), 32'(8'h11 * (j + 1)));
    end
    rx_frame(0, 8, 3 * FRAME, rd, rp, rok);
    check("t3_no_fifth_frame", 32'(rok),  32'd0);
    check("t3_idle",           32'(busy), 32'd0);

`ifdef UART_PARITY_EN
    // Parity of 8'h07: even -> 1, odd -> 0; parity_odd is held from the pop edge.
    parity_odd = 1'b0;
    wr_data = 8'h07; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    parity_odd = 1'b1;
    rx_frame(0, 8, 3 * FRAME, rd, rp, rok);
    check("t4_even_ok",     32'(rok),     32'd1);
    check("t4_even_data",   32'(rd[7:0]), 32'h07);
    check("t4_even_parity", 32'(rp),      32'd1);
    wr_data = 8'h07; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    rx_frame(0, 8, 3 * FRAME, rd, rp, rok);
    check("t4_odd_ok",     32'(rok), 32'd1);
    check("t4_odd_parity", 32'(rp),  32'd0);
    parity_odd = 1'b0;
    repeat (2 * DIV) tick();
`endif

    // Reset asserted 35 cycles into a frame with a second word queued.
    wr_data = 8'h00; wr_valid = 1'b1;
    tick();
    tick();
    wr_valid = 1'b0;
    repeat (35) tick();
    check("t5_tx_before",    32'(tx),         32'd0);
    check("t5_count_before", 32'(fifo_count), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_tx_reset",    32'(tx),         32'd1);
    check("t5_count_reset", 32'(fifo_count), 32'd0);
    check("t5_busy_reset",  32'(busy),       32'd0);
    tick();
    reset = 1'b1;
    tick();
    wr_data = 8'h5A; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    rx_frame(0, 8, 3 * FRAME, rd, rp, rok);
    check("t5_rx_ok",   32'(rok),     32'd1);
    check("t5_rx_data", 32'(rd[7:0]), 32'h5A);
    rx_frame(0, 8, 2 * FRAME, rd, rp, rok);
    check("t5_no_stale_frame", 32'(rok), 32'd0);

    // Seven data bits, two stop bits, 7'h55.
    d7 = 7'h55;
    wr_data2 = d7; wr_valid2 = 1'b1;
    tick();
    wr_valid2 = 1'b0;
    run_log(1, FRAME2 + 1);
    check_seg("t6_start", 0, DIV, 1'b0);
    for (int b = 0; b < 7; b++)
      check_seg($sformatf("t6_bit%0d", b), DIV * (1 + b), DIV, d7[b]);
    if (PB == 1) check_seg("t6_parity", DIV * 8, DIV, 1'b0);
    check_seg("t6_stop", DIV * (8 + PB), 2 * DIV, 1'b1);
    check("t6_busy_last", 32'(busy_log[FRAME2 - 1]), 32'd1);
    check("t6_busy_done", 32'(busy_log[FRAME2]),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
